// File: rtl/rs_encode_pkg.sv
// rtl/rs_encode_pkg.sv - shared types and sizing constants for the RS encode stream path
package rs_encode_pkg;

  typedef enum logic [1:0] {
    META_WAIT,
    DATA_OUT,
    PAR_OUT
  } out_ctrl_state_e;

  localparam int NUM_DATA_LINES = 8;
  localparam int PARITY_MEMS    = 2;
  localparam int MAX_BLOCKS     = 16;
  localparam int LINE_CNT_W     = $clog2(NUM_DATA_LINES);
  localparam int PARITY_ADDR_W  = $clog2(MAX_BLOCKS);

  // Parity lines streamed out for a request: blocks are packed PARITY_MEMS per line.
  function automatic int num_parity_lines(input int num_blocks);
    return (num_blocks + PARITY_MEMS - 1) / PARITY_MEMS;
  endfunction

endpackage

// File: rtl/rs_encode_rd_credit_cnt.sv
// rtl/rs_encode_rd_credit_cnt.sv - saturating up/down counter of parity reads in flight
module rs_encode_rd_credit_cnt #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam logic [W-1:0] MaxCnt = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign full_o  = (count_q == MaxCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rs_encode_stream_out_ctrl.sv
// rtl/rs_encode_stream_out_ctrl.sv - request sequencer: data lines, parity writes, parity read-out
module rs_encode_stream_out_ctrl
  import rs_encode_pkg::*;
#(
  parameter int MAX_RD_OUTSTANDING = 2,
  parameter int OUTSTANDING_W      = $clog2(MAX_RD_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_datap_out_ctrl_meta_val,
  output logic out_ctrl_in_datap_meta_rdy,
  input  logic line_encode_stream_encode_line_val,
  output logic stream_encode_line_encode_line_rdy,
  input  logic line_encode_stream_encode_parity_val,
  output logic stream_encoder_dst_resp_val,
  output logic stream_encoder_dst_resp_last,
  input  logic dst_stream_encoder_resp_rdy,
  output logic parity_mem_wr_val,
  output logic parity_mem_rd_req_val,
  input  logic parity_mem_rd_req_rdy,
  input  logic parity_mem_rd_resp_val,
  output logic parity_mem_rd_resp_rdy,
  output logic out_ctrl_out_datap_store_meta,
  output logic out_ctrl_out_datap_init_req_state,
  output logic out_ctrl_out_datap_incr_block_count,
  output logic out_ctrl_out_datap_init_line_count,
  output logic out_ctrl_out_datap_incr_line_count,
  output logic out_ctrl_out_datap_incr_parity_wr_addr,
  output logic out_ctrl_out_datap_incr_parity_rd_addr,
  output logic out_ctrl_out_datap_parity_out,
  input  logic out_datap_out_ctrl_last_block,
  input  logic out_datap_out_ctrl_last_data_line,
  input  logic out_datap_out_ctrl_last_parity_line
);

  out_ctrl_state_e state_q, state_d;

  logic                     in_par;
  logic                     data_beat;
  logic                     rd_req_ok;
  logic                     rd_accept;
  logic                     par_beat;
  logic                     par_done;
  logic [OUTSTANDING_W-1:0] rd_cnt;
  logic                     rd_cnt_full;
  logic                     rd_cnt_empty;

  assign in_par    = (state_q == PAR_OUT);
  assign data_beat = (state_q == DATA_OUT) & line_encode_stream_encode_line_val
                     & dst_stream_encoder_resp_rdy;
  assign rd_req_ok = in_par & !out_datap_out_ctrl_last_parity_line & !rd_cnt_full;
  assign rd_accept = rd_req_ok & parity_mem_rd_req_rdy;
  assign par_beat  = in_par & parity_mem_rd_resp_val & dst_stream_encoder_resp_rdy;
  // The final response is the one draining the last outstanding read after all addresses issued.
  assign par_done  = par_beat & out_datap_out_ctrl_last_parity_line
                     & (rd_cnt == OUTSTANDING_W'(1)) & !rd_accept;

  rs_encode_rd_credit_cnt #(
    .MAX (MAX_RD_OUTSTANDING),
    .W   (OUTSTANDING_W)
  ) u_rd_credit_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (rd_accept),
    .dec_i   (par_beat),
    .count_o (rd_cnt),
    .full_o  (rd_cnt_full),
    .empty_o (rd_cnt_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= META_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                                = state_q;
    out_ctrl_in_datap_meta_rdy             = 1'b0;
    stream_encode_line_encode_line_rdy     = 1'b0;
    stream_encoder_dst_resp_val            = 1'b0;
    stream_encoder_dst_resp_last           = 1'b0;
    parity_mem_wr_val                      = 1'b0;
    parity_mem_rd_req_val                  = 1'b0;
    parity_mem_rd_resp_rdy                 = 1'b0;
    out_ctrl_out_datap_store_meta          = 1'b0;
    out_ctrl_out_datap_init_req_state      = 1'b0;
    out_ctrl_out_datap_incr_block_count    = 1'b0;
    out_ctrl_out_datap_init_line_count     = 1'b0;
    out_ctrl_out_datap_incr_line_count     = 1'b0;
    out_ctrl_out_datap_incr_parity_wr_addr = 1'b0;
    out_ctrl_out_datap_incr_parity_rd_addr = 1'b0;
    out_ctrl_out_datap_parity_out          = 1'b0;

    unique case (state_q)
      META_WAIT: begin
        out_ctrl_in_datap_meta_rdy = 1'b1;
        if (in_datap_out_ctrl_meta_val) begin
          out_ctrl_out_datap_store_meta      = 1'b1;
          out_ctrl_out_datap_init_req_state  = 1'b1;
          out_ctrl_out_datap_init_line_count = 1'b1;
          state_d                            = DATA_OUT;
        end
      end
      DATA_OUT: begin
        stream_encoder_dst_resp_val        = line_encode_stream_encode_line_val;
        stream_encode_line_encode_line_rdy = dst_stream_encoder_resp_rdy;
        out_ctrl_out_datap_incr_line_count = data_beat;
        if (data_beat && out_datap_out_ctrl_last_data_line) begin
          parity_mem_wr_val                      = 1'b1;
          out_ctrl_out_datap_incr_parity_wr_addr = 1'b1;
          out_ctrl_out_datap_incr_block_count    = 1'b1;
          out_ctrl_out_datap_init_line_count     = 1'b1;
          if (out_datap_out_ctrl_last_block) begin
            state_d = PAR_OUT;
          end
        end
      end
      PAR_OUT: begin
        out_ctrl_out_datap_parity_out          = 1'b1;
        parity_mem_rd_req_val                  = rd_req_ok;
        out_ctrl_out_datap_incr_parity_rd_addr = rd_accept;
        stream_encoder_dst_resp_val            = parity_mem_rd_resp_val;
        parity_mem_rd_resp_rdy                 = dst_stream_encoder_resp_rdy;
        if (par_done) begin
          stream_encoder_dst_resp_last = 1'b1;
          state_d                      = META_WAIT;
        end
      end
      default: state_d = META_WAIT;
    endcase

    // Outputs stay silent for as long as reset is held.
    if (!rst_n) begin
      out_ctrl_in_datap_meta_rdy             = 1'b0;
      stream_encode_line_encode_line_rdy     = 1'b0;
      stream_encoder_dst_resp_val            = 1'b0;
      stream_encoder_dst_resp_last           = 1'b0;
      parity_mem_wr_val                      = 1'b0;
      parity_mem_rd_req_val                  = 1'b0;
      parity_mem_rd_resp_rdy                 = 1'b0;
      out_ctrl_out_datap_store_meta          = 1'b0;
      out_ctrl_out_datap_init_req_state      = 1'b0;
      out_ctrl_out_datap_incr_block_count    = 1'b0;
      out_ctrl_out_datap_init_line_count     = 1'b0;
      out_ctrl_out_datap_incr_line_count     = 1'b0;
      out_ctrl_out_datap_incr_parity_wr_addr = 1'b0;
      out_ctrl_out_datap_incr_parity_rd_addr = 1'b0;
      out_ctrl_out_datap_parity_out          = 1'b0;
    end
  end

  a_parity_on_last_line: assert property (@(posedge clk) disable iff (!rst_n)
    (data_beat && out_datap_out_ctrl_last_data_line) |-> line_encode_stream_encode_parity_val);

  a_rd_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    rd_cnt <= OUTSTANDING_W'(MAX_RD_OUTSTANDING));

  a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    par_beat |-> !rd_cnt_empty);

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// tb/tb_rs_encode_stream_out_ctrl.sv - self-checking bench for rs_encode_stream_out_ctrl
module tb_rs_encode_stream_out_ctrl;
  import rs_encode_pkg::*;

  localparam int NDL = NUM_DATA_LINES;
  localparam int PM  = PARITY_MEMS;
  localparam int MAXO = 2;

  logic clk, rst_n;
  logic in_datap_out_ctrl_meta_val, out_ctrl_in_datap_meta_rdy;
  logic line_encode_stream_encode_line_val, stream_encode_line_encode_line_rdy;
  logic line_encode_stream_encode_parity_val;
  logic stream_encoder_dst_resp_val, stream_encoder_dst_resp_last, dst_stream_encoder_resp_rdy;
  logic parity_mem_wr_val, parity_mem_rd_req_val, parity_mem_rd_req_rdy;
  logic parity_mem_rd_resp_val, parity_mem_rd_resp_rdy;
  logic out_ctrl_out_datap_store_meta, out_ctrl_out_datap_init_req_state;
  logic out_ctrl_out_datap_incr_block_count, out_ctrl_out_datap_init_line_count;
  logic out_ctrl_out_datap_incr_line_count, out_ctrl_out_datap_incr_parity_wr_addr;
  logic out_ctrl_out_datap_incr_parity_rd_addr, out_ctrl_out_datap_parity_out;
  logic out_datap_out_ctrl_last_block, out_datap_out_ctrl_last_data_line;
  logic out_datap_out_ctrl_last_parity_line;

  rs_encode_stream_out_ctrl dut (
    .clk                                    (clk),
    .rst_n                                  (rst_n),
    .in_datap_out_ctrl_meta_val             (in_datap_out_ctrl_meta_val),
    .out_ctrl_in_datap_meta_rdy             (out_ctrl_in_datap_meta_rdy),
    .line_encode_stream_encode_line_val     (line_encode_stream_encode_line_val),
    .stream_encode_line_encode_line_rdy     (stream_encode_line_encode_line_rdy),
    .line_encode_stream_encode_parity_val   (line_encode_stream_encode_parity_val),
    .stream_encoder_dst_resp_val            (stream_encoder_dst_resp_val),
    .stream_encoder_dst_resp_last           (stream_encoder_dst_resp_last),
    .dst_stream_encoder_resp_rdy            (dst_stream_encoder_resp_rdy),
    .parity_mem_wr_val                      (parity_mem_wr_val),
    .parity_mem_rd_req_val                  (parity_mem_rd_req_val),
    .parity_mem_rd_req_rdy                  (parity_mem_rd_req_rdy),
    .parity_mem_rd_resp_val                 (parity_mem_rd_resp_val),
    .parity_mem_rd_resp_rdy                 (parity_mem_rd_resp_rdy),
    .out_ctrl_out_datap_store_meta          (out_ctrl_out_datap_store_meta),
    .out_ctrl_out_datap_init_req_state      (out_ctrl_out_datap_init_req_state),
    .out_ctrl_out_datap_incr_block_count    (out_ctrl_out_datap_incr_block_count),
    .out_ctrl_out_datap_init_line_count     (out_ctrl_out_datap_init_line_count),
    .out_ctrl_out_datap_incr_line_count     (out_ctrl_out_datap_incr_line_count),
    .out_ctrl_out_datap_incr_parity_wr_addr (out_ctrl_out_datap_incr_parity_wr_addr),
    .out_ctrl_out_datap_incr_parity_rd_addr (out_ctrl_out_datap_incr_parity_rd_addr),
    .out_ctrl_out_datap_parity_out          (out_ctrl_out_datap_parity_out),
    .out_datap_out_ctrl_last_block          (out_datap_out_ctrl_last_block),
    .out_datap_out_ctrl_last_data_line      (out_datap_out_ctrl_last_data_line),
    .out_datap_out_ctrl_last_parity_line    (out_datap_out_ctrl_last_parity_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic meta_rdy, line_rdy, resp_val, resp_last, wr_val, req_val, resp_rdy;
    logic store, init_req, incr_blk, init_line, incr_line, incr_wr, incr_rd, par_out;
  } outs_t;

  typedef struct {
    int nb; int dpct; int rpct; int rstall; int lat; int hlo; int exp_db; int exp_pb;
  } scen_t;

  typedef struct {
    int addr; int rdy_at;
  } rd_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  // datap + parity memory environment
  int nb_m, npar_m, line_m, blk_m, wr_m, rd_m;
  rd_t rq[$];
  // request-level reference state
  int phase, r_nb, r_npar, db, pb, ra, par_cyc;
  bit ln_hold;
  int obs_db, obs_pb, obs_wr, obs_blk, obs_last, cur_out, max_out;

  function automatic outs_t get_outs();
    outs_t o;
    o = '{out_ctrl_in_datap_meta_rdy, stream_encode_line_encode_line_rdy,
          stream_encoder_dst_resp_val, stream_encoder_dst_resp_last, parity_mem_wr_val,
          parity_mem_rd_req_val, parity_mem_rd_resp_rdy, out_ctrl_out_datap_store_meta,
          out_ctrl_out_datap_init_req_state, out_ctrl_out_datap_incr_block_count,
          out_ctrl_out_datap_init_line_count, out_ctrl_out_datap_incr_line_count,
          out_ctrl_out_datap_incr_parity_wr_addr, out_ctrl_out_datap_incr_parity_rd_addr,
          out_ctrl_out_datap_parity_out};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic env_reset();
    nb_m = 0; npar_m = 0; line_m = 0; blk_m = 0; wr_m = 0; rd_m = 0;
    rq.delete();
  endtask

  task automatic drive_flags();
    out_datap_out_ctrl_last_data_line   = (line_m == NDL - 1);
    out_datap_out_ctrl_last_block       = (blk_m == nb_m - 1);
    out_datap_out_ctrl_last_parity_line = (rd_m >= npar_m);
    parity_mem_rd_resp_val = (rq.size() > 0) && (rq[0].rdy_at <= cyc);
  endtask

  // One request from metadata to last parity beat; abort_db >= 0 returns mid-data with inputs driven.
  task automatic run_req(input int nblk, input int dpct, input int rpct, input int rstall,
                         input int lat, input int hlo, input int exp_db, input int exp_pb,
                         input int abort_db);
    outs_t a, e;
    bit beat, pbeat, acc, done;
    int guard;
    phase = 0; r_nb = nblk; r_npar = (nblk + PM - 1) / PM;
    db = 0; pb = 0; ra = 0; par_cyc = 0; ln_hold = 0; done = 0; guard = 0;
    obs_db = 0; obs_pb = 0; obs_wr = 0; obs_blk = 0; obs_last = 0; cur_out = 0; max_out = 0;
    while (!done && guard < 3000) begin
      in_datap_out_ctrl_meta_val = (phase == 0);
      if (phase == 1) begin
        if (!ln_hold) line_encode_stream_encode_line_val = ($urandom_range(99) < 80);
      end else begin
        line_encode_stream_encode_line_val = 1'b0;
      end
      line_encode_stream_encode_parity_val = line_encode_stream_encode_line_val && (db % NDL == NDL - 1);
      dst_stream_encoder_resp_rdy = (phase == 2 && par_cyc < hlo) ? 1'b0 : ($urandom_range(99) < dpct);
      parity_mem_rd_req_rdy = (phase == 2 && par_cyc < rstall) ? 1'b0 : ($urandom_range(99) < rpct);
      drive_flags();
      if (abort_db >= 0 && phase == 1 && db >= abort_db) return;
      #4;
      e = '0; beat = 0; pbeat = 0; acc = 0;
      case (phase)
        0: begin e.meta_rdy = 1; e.store = 1; e.init_req = 1; e.init_line = 1; end
        1: begin
          beat = line_encode_stream_encode_line_val && dst_stream_encoder_resp_rdy;
          e.resp_val = line_encode_stream_encode_line_val;
          e.line_rdy = dst_stream_encoder_resp_rdy;
          e.incr_line = beat;
          if (beat && (db % NDL == NDL - 1)) begin
            e.wr_val = 1; e.incr_wr = 1; e.incr_blk = 1; e.init_line = 1;
          end
        end
        default: begin
          e.par_out = 1;
          e.req_val = (ra < r_npar) && (ra - pb < MAXO);
          acc = e.req_val && parity_mem_rd_req_rdy;
          e.incr_rd = acc;
          e.resp_val = parity_mem_rd_resp_val;
          e.resp_rdy = dst_stream_encoder_resp_rdy;
          pbeat = parity_mem_rd_resp_val && dst_stream_encoder_resp_rdy;
          e.resp_last = pbeat && (pb == r_npar - 1);
        end
      endcase
      a = get_outs();
      chk("cycle_outputs", 32'(a), 32'(e));
      if (a.resp_val && dst_stream_encoder_resp_rdy && !a.par_out) obs_db++;
      if (a.resp_val && dst_stream_encoder_resp_rdy && a.par_out) begin
        obs_pb++;
        if (rq.size() > 0) chk("par_addr_order", rq[0].addr, pb);
      end
      if (a.wr_val) begin chk("wr_addr", wr_m, obs_wr); obs_wr++; end
      if (a.incr_blk) obs_blk++;
      if (a.resp_last) obs_last++;
      @(posedge clk); #1;
      if (a.init_req) begin blk_m = 0; wr_m = 0; rd_m = 0; end
      if (a.store) begin nb_m = nblk; npar_m = (nblk + PM - 1) / PM; end
      if (a.init_line) line_m = 0; else if (a.incr_line) line_m++;
      if (a.incr_blk) blk_m++;
      if (a.incr_wr) wr_m++;
      if (a.req_val && parity_mem_rd_req_rdy) begin
        rq.push_back('{rd_m, cyc + lat}); cur_out++;
      end
      if (a.incr_rd) rd_m++;
      if (parity_mem_rd_resp_val && a.resp_rdy && a.par_out) begin
        if (rq.size() > 0) void'(rq.pop_front());
        cur_out--;
      end
      if (cur_out > max_out) max_out = cur_out;
      cyc++; guard++;
      case (phase)
        0: phase = 1;
        1: begin
          ln_hold = line_encode_stream_encode_line_val && !beat;
          if (beat) db++;
          if (db == r_nb * NDL) phase = 2;
        end
        default: begin
          if (acc) ra++;
          if (pbeat) pb++;
          par_cyc++;
          if (pb == r_npar) done = 1;
        end
      endcase
    end
    if (!done) chk("request_timeout", 32'd1, 32'd0);
    chk("data_beats", obs_db, exp_db);
    chk("parity_beats", obs_pb, exp_pb);
    chk("wr_pulses", obs_wr, nblk);
    chk("blk_incr_pulses", obs_blk, nblk);
    chk("last_count", obs_last, 1);
    chk("max_outstanding_ok", 32'(max_out <= MAXO), 32'd1);
  endtask

  task automatic idle(input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      in_datap_out_ctrl_meta_val = 1'b0;
      line_encode_stream_encode_line_val = 1'b1;
      dst_stream_encoder_resp_rdy = 1'b1;
      parity_mem_rd_req_rdy = 1'b1;
      drive_flags();
      parity_mem_rd_resp_val = 1'b1;
      #4;
      e = '0; e.meta_rdy = 1;
      chk("idle_outputs", 32'(get_outs()), 32'(e));
      @(posedge clk); #1; cyc++;
    end
  endtask

  scen_t tbl[5];

  initial begin
    tbl[0] = '{nb:1, dpct:100, rpct:100, rstall:0, lat:1, hlo:0,  exp_db:8,  exp_pb:1};
    tbl[1] = '{nb:4, dpct:50,  rpct:100, rstall:0, lat:1, hlo:0,  exp_db:32, exp_pb:2};
    tbl[2] = '{nb:3, dpct:100, rpct:100, rstall:3, lat:2, hlo:0,  exp_db:24, exp_pb:2};
    tbl[3] = '{nb:5, dpct:100, rpct:100, rstall:0, lat:2, hlo:10, exp_db:40, exp_pb:3};
    tbl[4] = '{nb:2, dpct:70,  rpct:60,  rstall:0, lat:3, hlo:0,  exp_db:16, exp_pb:1};

    env_reset();
    rst_n = 1'b0;
    in_datap_out_ctrl_meta_val = 1'b1;
    line_encode_stream_encode_line_val = 1'b1;
    line_encode_stream_encode_parity_val = 1'b0;
    dst_stream_encoder_resp_rdy = 1'b1;
    parity_mem_rd_req_rdy = 1'b1;
    drive_flags();
    parity_mem_rd_resp_val = 1'b1;
    #3;
    chk("reset_outputs", 32'(get_outs()), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 5; i++)
      run_req(tbl[i].nb, tbl[i].dpct, tbl[i].rpct, tbl[i].rstall, tbl[i].lat, tbl[i].hlo,
              tbl[i].exp_db, tbl[i].exp_pb, -1);

    for (int i = 0; i < 6; i++) begin
      int nb;
      nb = $urandom_range(6, 1);
      run_req(nb, $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(3, 0),
              $urandom_range(4, 1), 0, nb * NDL, (nb + PM - 1) / PM, -1);
    end

    // Reset during the second block of a four-block request.
    run_req(4, 100, 100, 0, 1, 0, 32, 2, NDL + 3);
    in_datap_out_ctrl_meta_val = 1'b1;
    line_encode_stream_encode_line_val = 1'b1;
    #1; rst_n = 1'b0; #1;
    chk("mid_reset_outputs", 32'(get_outs()), 32'd0);
    @(posedge clk); #4;
    chk("mid_reset_held", 32'(get_outs()), 32'd0);
    env_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    run_req(1, 100, 100, 0, 1, 0, 8, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
